kgp_multicycle_ctrl: RTL and testbench
======================================

Name: kgp_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the KGP-RISC core.
- Sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Takes opcode/funcode from the instruction decoder and a branch-taken flag from the branch comparator.
- Drives instruction-memory and data-memory request/ready handshakes, IR/PC/regfile/flag write enables, and writeback/PC source selects; counts retired instructions.

Parameters:
COUNT_W, 32, width of retired-instruction counter
HALT_OPC, 4'b1111, opcode that halts the core
LINK_FUNC, 4'b0001, funcode of opcode 0100 that also writes the link register

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  4  decoded opcode, stable from DECODE until next ir_load
funcode  in  4  decoded function code
br_taken  in  1  branch condition result, valid in EXEC
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load (valid while dmem_req)
ir_load  out  1  latch fetched word into IR
pc_inc  out  1  PC <= PC+1
pc_load  out  1  PC <= branch target
pc_src  out  1  0 = PC-relative imm, 1 = register (reg1)
alu_src  out  1  0 = reg2, 1 = imm
flag_we  out  1  update carry/zero/sign flags
reg_write  out  1  regfile write enable
wb_sel  out  2  00 ALU, 01 MEM, 10 LINK (old PC+1)
halted  out  1  core halted
retired  out  COUNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock clk; reset rst_n asynchronous, active-low.
- Reset: state=FETCH, retired=0, halted=0. Every strobe and select is 0, including wb_sel=00. A reset mid-access drops the request in the same instant; no write completes.
- Output style: Moore outputs decoded from the state register and opcode/funcode. No output depends on imem_ready or dmem_ready, except ir_load/pc_inc, which are qualified by imem_ready.
- FETCH: imem_req=1 and held until imem_ready. In the cycle imem_ready=1: ir_load=1 and pc_inc=1 for one cycle, next state DECODE. Without imem_ready, stay in FETCH.
- DECODE: one cycle, register-file read only; next state EXEC.
- EXEC: one cycle; actions by opcode.
  - 0000 R-type: alu_src=0, flag_we=1 -> WB (wb_sel 00).
  - 0001 imm-ALU: alu_src=1, flag_we=1 -> WB.
  - 0010 load / 0011 store: alu_src=1 (address = reg + imm) -> MEM.
  - 0100 uncond/flag branch: pc_src=0, pc_load=br_taken. If funcode==LINK_FUNC -> WB (wb_sel 10); else -> FETCH.
  - 0101 jump register: pc_src=1, pc_load=1 (ignores br_taken) -> FETCH.
  - 0110 reg-conditional branch: pc_src=0, pc_load=br_taken -> FETCH.
  - HALT_OPC -> HALT.
  - Any other opcode: NOP -> FETCH.
- MEM: dmem_req=1, dmem_we=(opcode==0011), held stable until dmem_ready. On dmem_ready: load -> WB (wb_sel 01); store -> FETCH.
- WB: reg_write=1 for one cycle with wb_sel as above -> FETCH.
- Retirement: retired increments by 1 on each transition into FETCH from EXEC, MEM or WB, and on entry to HALT. It wraps modulo 2^COUNT_W.
- HALT: halted=1, all requests and strobes 0; sticky until rst_n is asserted.
- Cycle counts with zero-wait memory (imem_ready/dmem_ready high in the first request cycle): ALU = 4 cycles, load = 5, store = 4, branch = 3, link-branch = 4.
- Every wait cycle on imem_ready or dmem_ready adds exactly one cycle.
- pc_load and pc_inc are never asserted together; reg_write and dmem_req are never asserted together.

Decomposition:
- Package kgp_ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - opcode constants OPC_RTYPE..OPC_BRCOND;
  - WB_ALU/WB_MEM/WB_LINK encodings;
  - PC_REL/PC_REG encodings.
- One natural sub-module: kgp_retire_counter, a COUNT_W counter with increment enable and async active-low clear.

Test Plan:
- Reset: rst_n=0 asserted mid-MEM with dmem_req=1 -> dmem_req=0 immediately, state FETCH, retired=0 after release.
- R-type, zero-wait: opcode=0000, imem_ready tied 1 -> ir_load/pc_inc at cycle 1, flag_we at cycle 3, reg_write with wb_sel=00 at cycle 4, retired=1.
- Load with waits: opcode=0010, dmem_ready held low 3 cycles -> dmem_req=1 and dmem_we=0 stable for 4 cycles, then reg_write with wb_sel=01, total 8 cycles.
- Branches:
  - opcode=0110, br_taken=0 -> pc_load=0.
  - opcode=0110, br_taken=1 -> pc_load=1, pc_src=0.
  - opcode=0100, funcode=0001, br_taken=1 -> pc_load=1, then reg_write with wb_sel=10.
- Jump register: opcode=0101, br_taken=0 -> pc_load=1, pc_src=1, no reg_write.
- Halt and counter wrap: opcode=1111 -> halted=1 and no imem_req on any subsequent cycle. With COUNT_W=4 and 16 NOPs (opcode=0111), retired wraps to 0.

Source files
------------

// File: rtl/kgp_ctrl_pkg.sv
// Shared types and encodings for the KGP-RISC multi-cycle controller.
package kgp_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OPC_RTYPE  = 4'b0000;
   localparam logic [3:0] OPC_IMM    = 4'b0001;
   localparam logic [3:0] OPC_LOAD   = 4'b0010;
   localparam logic [3:0] OPC_STORE  = 4'b0011;
   localparam logic [3:0] OPC_BRANCH = 4'b0100;
   localparam logic [3:0] OPC_JR     = 4'b0101;
   localparam logic [3:0] OPC_BRCOND = 4'b0110;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_LINK = 2'b10;

   localparam logic PC_REL = 1'b0;
   localparam logic PC_REG = 1'b1;

endpackage

// File: rtl/kgp_retire_counter.sv
// Retired-instruction counter; wraps modulo 2^COUNT_W.
module kgp_retire_counter #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inc,
   output logic [COUNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (inc)
         count <= count + COUNT_W'(1);
   end

endmodule

// File: rtl/kgp_multicycle_ctrl.sv
// Multi-cycle control FSM for the KGP-RISC core: fetch, decode, execute,
// memory and writeback for one instruction at a time.
module kgp_multicycle_ctrl
   import kgp_ctrl_pkg::*;
#(
   parameter int         COUNT_W   = 32,
   parameter logic [3:0] HALT_OPC  = 4'b1111,
   parameter logic [3:0] LINK_FUNC = 4'b0001
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         opcode,
   input  logic [3:0]         funcode,
   input  logic               br_taken,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   output logic               imem_req,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic               ir_load,
   output logic               pc_inc,
   output logic               pc_load,
   output logic               pc_src,
   output logic               alu_src,
   output logic               flag_we,
   output logic               reg_write,
   output logic [1:0]         wb_sel,
   output logic               halted,
   output logic [COUNT_W-1:0] retired
);

   state_t state, nstate;
   logic   retire_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= FETCH;
      else
         state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         FETCH:  if (imem_ready) nstate = DECODE;
         DECODE: nstate = EXEC;
         EXEC: begin
            if (opcode == HALT_OPC)
               nstate = HALT;
            else begin
               case (opcode)
                  OPC_RTYPE, OPC_IMM:  nstate = WB;
                  OPC_LOAD, OPC_STORE: nstate = MEM;
                  OPC_BRANCH:          nstate = (funcode == LINK_FUNC) ? WB : FETCH;
                  default:             nstate = FETCH;
               endcase
            end
         end
         MEM:    if (dmem_ready) nstate = (opcode == OPC_STORE) ? FETCH : WB;
         WB:     nstate = FETCH;
         HALT:   nstate = HALT;
         default: nstate = FETCH;
      endcase
   end

   // An instruction retires when control returns to FETCH or the core halts.
   assign retire_inc = ((nstate == FETCH) && (state == EXEC || state == MEM || state == WB)) ||
                       ((nstate == HALT) && (state != HALT));

   // Outputs are forced low while rst_n is held so an in-flight request drops at once.
   always_comb begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      pc_src    = PC_REL;
      alu_src   = 1'b0;
      flag_we   = 1'b0;
      reg_write = 1'b0;
      wb_sel    = WB_ALU;
      halted    = 1'b0;
      if (rst_n) begin
         case (state)
            FETCH: begin
               imem_req = 1'b1;
               ir_load  = imem_ready;
               pc_inc   = imem_ready;
            end
            EXEC: begin
               if (opcode != HALT_OPC) begin
                  case (opcode)
                     OPC_RTYPE:           flag_we = 1'b1;
                     OPC_IMM: begin
                        alu_src = 1'b1;
                        flag_we = 1'b1;
                     end
                     OPC_LOAD, OPC_STORE: alu_src = 1'b1;
                     OPC_BRANCH, OPC_BRCOND: begin
                        pc_src  = PC_REL;
                        pc_load = br_taken;
                     end
                     OPC_JR: begin
                        pc_src  = PC_REG;
                        pc_load = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (opcode == OPC_STORE);
            end
            WB: begin
               reg_write = 1'b1;
               if (opcode == OPC_LOAD)
                  wb_sel = WB_MEM;
               else if (opcode == OPC_BRANCH)
                  wb_sel = WB_LINK;
               else
                  wb_sel = WB_ALU;
            end
            HALT:    halted = 1'b1;
            default: ;
         endcase
      end
   end

   kgp_retire_counter #(.COUNT_W(COUNT_W)) u_retire (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (retire_inc),
      .count (retired)
   );

endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// Randomized bench for kgp_multicycle_ctrl: each instruction is expanded into
// its expected per-cycle output trace and replayed against the DUT.
module tb_kgp_multicycle_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    opcode = '0, funcode = '0;
   logic          br_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
   logic          imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load;
   logic          pc_src, alu_src, flag_we, reg_write, halted;
   logic [1:0]    wb_sel;
   logic [CW-1:0] retired;
   logic [12:0]   obs;

   int errors = 0;
   int checks = 0;
   logic [CW-1:0] nret = '0;

   typedef struct {
      logic        ir;
      logic        dr;
      logic [12:0] exp;
   } cyc_t;
   cyc_t plan[$];

   kgp_multicycle_ctrl #(.COUNT_W(CW), .HALT_OPC(4'b1111), .LINK_FUNC(4'b0001)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funcode(funcode), .br_taken(br_taken),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_load(ir_load), .pc_inc(pc_inc),
      .pc_load(pc_load), .pc_src(pc_src), .alu_src(alu_src), .flag_we(flag_we),
      .reg_write(reg_write), .wb_sel(wb_sel), .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   assign obs = {imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, pc_src,
                 alu_src, flag_we, reg_write, wb_sel, halted};

   function automatic logic [12:0] mk(input logic ireq, dreq, dwe, irl, pinc, pld,
                                      psrc, asrc, fwe, rwe, input logic [1:0] wb,
                                      input logic hlt);
      return {ireq, dreq, dwe, irl, pinc, pld, psrc, asrc, fwe, rwe, wb, hlt};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void push(input logic ir, input logic dr, input logic [12:0] e);
      cyc_t c;
      c.ir = ir; c.dr = dr; c.exp = e;
      plan.push_back(c);
   endfunction

   // Expand one instruction into its cycle-by-cycle trace from the ISA rules.
   function automatic void planInstr(input logic [3:0] opc, input logic [3:0] fn,
                                     input logic bt, input int iw, input int dw);
      logic link, isalu, ismem, isst;
      link  = (opc == 4'b0100) && (fn == 4'b0001);
      isalu = (opc == 4'b0000) || (opc == 4'b0001);
      isst  = (opc == 4'b0011);
      ismem = (opc == 4'b0010) || isst;
      plan.delete();
      for (int i = 0; i < iw; i++)
         push(1'b0, 1'($urandom), mk(1,0,0,0,0,0,0,0,0,0,2'b00,0));
      push(1'b1, 1'($urandom), mk(1,0,0,1,1,0,0,0,0,0,2'b00,0));
      push(1'($urandom), 1'($urandom), '0);
      if (opc == 4'b0000)      push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,0,0,1,0,2'b00,0));
      else if (opc == 4'b0001) push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,0,1,1,0,2'b00,0));
      else if (ismem)          push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,0,1,0,0,2'b00,0));
      else if (opc == 4'b0100 || opc == 4'b0110)
                               push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,bt,0,0,0,0,2'b00,0));
      else if (opc == 4'b0101) push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,1,1,0,0,0,2'b00,0));
      else                     push(1'($urandom), 1'($urandom), '0);
      if (ismem) begin
         for (int i = 0; i <= dw; i++)
            push(1'($urandom), (i == dw), mk(0,1,isst,0,0,0,0,0,0,0,2'b00,0));
      end
      if (isalu)                push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,0,0,0,1,2'b00,0));
      else if (ismem && !isst)  push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,0,0,0,1,2'b01,0));
      else if (link)            push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,0,0,0,1,2'b10,0));
   endfunction

   task automatic runPlan(input logic [3:0] opc, input logic [3:0] fn, input logic bt,
                          input int limit);
      for (int i = 0; i < plan.size() && i < limit; i++) begin
         @(negedge clk);
         opcode     = opc;
         funcode    = fn;
         br_taken   = bt;
         imem_ready = plan[i].ir;
         dmem_ready = plan[i].dr;
         #2;
         checkOutput("outs", 32'(obs), 32'(plan[i].exp));
         checkOutput("retired", 32'(retired), 32'(nret));
      end
   endtask

   task automatic applyStimulus(input logic [3:0] opc, input logic [3:0] fn, input logic bt,
                                input int iw, input int dw);
      planInstr(opc, fn, bt, iw, dw);
      runPlan(opc, fn, bt, plan.size());
      nret = nret + 1'b1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      dmem_ready = 1'b0;
      #1;
      checkOutput("rst_outs", 32'(obs), 32'h0);
      @(negedge clk);
      #1;
      checkOutput("rst_retired", 32'(retired), 32'h0);
      imem_ready = 1'b0;
      rst_n = 1'b1;
      nret = '0;
      #1;
      checkOutput("rel_fetch", 32'(obs), 32'(mk(1,0,0,0,0,0,0,0,0,0,2'b00,0)));
   endtask

   initial begin
      logic [3:0] o, f;
      doReset();

      // Directed cases
      applyStimulus(4'b0000, 4'b0000, 1'b0, 0, 0);
      applyStimulus(4'b0010, 4'b0000, 1'b0, 0, 3);
      applyStimulus(4'b0011, 4'b0000, 1'b1, 2, 1);
      applyStimulus(4'b0110, 4'b0000, 1'b0, 0, 0);
      applyStimulus(4'b0110, 4'b0000, 1'b1, 0, 0);
      applyStimulus(4'b0100, 4'b0001, 1'b1, 0, 0);
      applyStimulus(4'b0100, 4'b0010, 1'b1, 1, 0);
      applyStimulus(4'b0101, 4'b0000, 1'b0, 0, 0);
      applyStimulus(4'b0001, 4'b0000, 1'b0, 1, 0);

      // Reset in the middle of a load's memory wait
      planInstr(4'b0010, 4'b0000, 1'b0, 0, 6);
      runPlan(4'b0010, 4'b0000, 1'b0, 5);
      checkOutput("mid_mem_req", 32'(dmem_req), 32'h1);
      doReset();

      // Counter wrap: 16 NOPs bring a 4-bit count back to zero
      for (int i = 0; i < 16; i++)
         applyStimulus(4'b0111, 4'($urandom), 1'($urandom), 0, 0);
      @(negedge clk);
      #2;
      checkOutput("wrap", 32'(retired), 32'h0);
      imem_ready = 1'b0;

      // Random instruction mix
      for (int i = 0; i < 40; i++) begin
         o = 4'($urandom_range(0, 14));
         f = ($urandom_range(0, 1) == 1) ? 4'b0001 : 4'($urandom);
         applyStimulus(o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
      end

      // Halt is sticky and never requests another fetch
      applyStimulus(4'b1111, 4'b0000, 1'b0, 1, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         opcode     = 4'($urandom);
         imem_ready = 1'($urandom);
         dmem_ready = 1'($urandom);
         br_taken   = 1'($urandom);
         #2;
         checkOutput("halt_outs", 32'(obs), 32'(mk(0,0,0,0,0,0,0,0,0,0,2'b00,1)));
         checkOutput("halt_retired", 32'(retired), 32'(nret));
      end
      doReset();
      applyStimulus(4'b0000, 4'b0000, 1'b0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
